// File: rtl/lsu_mem_align.sv
// Load/store alignment stage: turns byte/half/word requests into word-addressed
// lane strobes for data_mem_be and returns aligned, extended load data in order.
module lsu_mem_align #(
  parameter int DM_AW     = 10,
  parameter int DM_DW     = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [DM_AW-1:0] req_addr,
  input  logic [DM_DW-1:0] req_wdata,
  output logic [3:0]       mem_be,
  output logic [DM_AW-1:0] mem_addr,
  output logic [DM_DW-1:0] mem_wdata,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  input  logic [DM_DW-1:0] mem_rdata,
  input  logic             mem_rdata_vld,
  output logic             rsp_vld,
  output logic [DM_DW-1:0] rsp_data,
  output logic             align_err,
  output logic             unexp_err
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int QW = $clog2(RD_LAT + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       sgn;
  } meta_t;

  meta_t             fifo_mem [MAX_OUTST];
  meta_t             push_meta;
  meta_t             head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              req_err;
  logic              accept;
  logic              issue_wr;
  logic              issue_rd;
  logic [3:0]        lane_be;
  logic [DM_DW-1:0]  lane_wdata;

  logic [QW-1:0]     quiet_cnt;
  logic              quiet;

  logic [DM_DW-1:0]  shifted;
  logic [DM_DW-1:0]  ext_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request handshake: a request transfers on a cycle with req_vld && req_rdy;
  // responses are single-cycle rsp_vld pulses with no backpressure.
  assign fifo_full  = (count == CW'(MAX_OUTST));
  assign fifo_empty = (count == '0);
  assign req_rdy    = !fifo_full || req_we;
  assign accept     = req_vld && req_rdy;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  assign issue_wr = accept &&  req_we && !req_err;
  assign issue_rd = accept && !req_we && !req_err;

  always_comb begin
    lane_be    = 4'hF;
    lane_wdata = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = 4'b0011 << req_addr[1:0];
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'hF;
        lane_wdata = req_wdata;
      end
    endcase
    if (!req_we) lane_be = 4'hF;
  end

  assign mem_wr_en = issue_wr;
  assign mem_rd_en = issue_rd;
  assign mem_addr  = {req_addr[DM_AW-1:2], 2'b00};
  assign mem_be    = (issue_wr || issue_rd) ? lane_be : 4'h0;
  assign mem_wdata = issue_wr ? lane_wdata : '0;

  // Read returns during the post-reset quiet window belong to reads issued
  // before reset, so they are ignored rather than matched against new loads.
  assign quiet = (quiet_cnt < QW'(RD_LAT));
  assign push  = issue_rd;
  assign pop   = mem_rdata_vld && !fifo_empty && !quiet;

  always_comb begin
    push_meta      = '0;
    push_meta.off  = req_addr[1:0];
    push_meta.size = req_size;
    push_meta.sgn  = req_signed;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_meta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt <= '0;
    end else if (quiet) begin
      quiet_cnt <= quiet_cnt + QW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unexp_err <= 1'b0;
    end else if (mem_rdata_vld && fifo_empty && !quiet) begin
      unexp_err <= 1'b1;
    end
  end

  assign head    = fifo_mem[rd_ptr];
  assign shifted = mem_rdata >> {head.off, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (head.size)
      SZ_BYTE: ext_data = head.sgn ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h0, shifted[7:0]};
      SZ_HALF: ext_data = head.sgn ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      align_err <= 1'b0;
    end else begin
      rsp_vld   <= pop;
      align_err <= accept && req_err;
      if (pop) rsp_data <= ext_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_align.sv
// Bench for lsu_mem_align: two instances (RD_LAT=1/MAX_OUTST=4 and
// RD_LAT=3/MAX_OUTST=2), each backed by a small latency memory model.
module tb_lsu_mem_align;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  req_vld;
  logic [1:0]  req_we;
  logic [1:0]  req_signed;
  logic [1:0]  inj;
  logic [1:0]  req_size  [2];
  logic [9:0]  req_addr  [2];
  logic [31:0] req_wdata [2];

  wire  [1:0]  req_rdy;
  wire  [1:0]  mem_wr_en;
  wire  [1:0]  mem_rd_en;
  wire  [1:0]  mem_rdata_vld;
  wire  [1:0]  rsp_vld;
  wire  [1:0]  align_err;
  wire  [1:0]  unexp_err;
  wire  [3:0]  mem_be    [2];
  wire  [9:0]  mem_addr  [2];
  wire  [31:0] mem_wdata [2];
  wire  [31:0] mem_rdata [2];
  wire  [31:0] rsp_data  [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          exp_c0[$];
  int          exp_c1[$];

  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_align #(.DM_AW(10), .DM_DW(32), .RD_LAT(1), .MAX_OUTST(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .mem_be(mem_be[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wr_en(mem_wr_en[0]), .mem_rd_en(mem_rd_en[0]),
    .mem_rdata(mem_rdata[0]), .mem_rdata_vld(mem_rdata_vld[0]),
    .rsp_vld(rsp_vld[0]), .rsp_data(rsp_data[0]),
    .align_err(align_err[0]), .unexp_err(unexp_err[0])
  );

  lsu_mem_align #(.DM_AW(10), .DM_DW(32), .RD_LAT(3), .MAX_OUTST(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .mem_be(mem_be[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wr_en(mem_wr_en[1]), .mem_rd_en(mem_rd_en[1]),
    .mem_rdata(mem_rdata[1]), .mem_rdata_vld(mem_rdata_vld[1]),
    .rsp_vld(rsp_vld[1]), .rsp_data(rsp_data[1]),
    .align_err(align_err[1]), .unexp_err(unexp_err[1])
  );

  // Memory models keep running through DUT reset, like a real data_mem_be.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem_arr [256];
    logic [3:0]  pv = 4'h0;
    logic [31:0] pd [4];
    always @(posedge clk) begin
      if (mem_wr_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) mem_arr[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      pv    <= {pv[2:0], mem_rd_en[g]};
      pd[0] <= mem_arr[mem_addr[g][9:2]];
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    end
    assign mem_rdata_vld[g] = pv[LAT-1] | inj[g];
    assign mem_rdata[g]     = pd[LAT-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input int s);
    logic [31:0] e;
    int c;
    if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_unexpected[%0d]: got rsp_data %h expected no response", s, rsp_data[s]);
      return;
    end
    if (s == 0) begin e = exp_q0.pop_front(); c = exp_c0.pop_front(); end
    else        begin e = exp_q1.pop_front(); c = exp_c1.pop_front(); end
    chk($sformatf("rsp_data[%0d]", s), rsp_data[s], e);
    chk($sformatf("rsp_cycle[%0d]", s), cyc, c);
  endtask

  // Monitor: every response pulse is matched against the expected queue.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      if (rsp_vld[s] === 1'b1) check_rsp(s);
  end

  task automatic issue(input int s, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [9:0] a, input logic [31:0] d, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic exp_err, input logic [31:0] exp_rsp);
    int waited;
    logic e_wr, e_rd;
    waited = 0;
    e_wr = we && !exp_err;
    e_rd = !we && !exp_err;
    @(negedge clk);
    req_vld[s] = 1'b1; req_we[s] = we; req_size[s] = sz; req_signed[s] = sgn;
    req_addr[s] = a; req_wdata[s] = d;
    #1;
    while (req_rdy[s] !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (req_rdy[s] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_rdy_timeout[%0d]: got %b expected 1", s, req_rdy[s]);
      req_vld[s] = 1'b0;
      return;
    end
    chk($sformatf("mem_wr_en[%0d]", s), mem_wr_en[s], e_wr);
    chk($sformatf("mem_rd_en[%0d]", s), mem_rd_en[s], e_rd);
    if (!exp_err) begin
      chk($sformatf("mem_be[%0d]", s), mem_be[s], exp_be);
      chk($sformatf("mem_addr[%0d]", s), mem_addr[s], {a[9:2], 2'b00});
      if (we) chk($sformatf("mem_wdata[%0d]", s), mem_wdata[s], exp_wd);
    end
    if (e_rd) begin
      if (s == 0) begin exp_q0.push_back(exp_rsp); exp_c0.push_back(cyc + 2); end
      else        begin exp_q1.push_back(exp_rsp); exp_c1.push_back(cyc + 4); end
    end
    @(posedge clk); #1;
    req_vld[s] = 1'b0;
    chk($sformatf("align_err[%0d]", s), align_err[s], exp_err);
  endtask

  task automatic st(input int s, input logic [1:0] sz, input logic [9:0] a,
                    input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
    issue(s, 1'b1, sz, 1'b0, a, d, be, wd, 1'b0, 32'h0);
  endtask

  task automatic ld(input int s, input logic [1:0] sz, input logic sgn,
                    input logic [9:0] a, input logic [31:0] exp);
    issue(s, 1'b0, sz, sgn, a, 32'h0, 4'hF, 32'h0, 1'b0, exp);
  endtask

  task automatic bad(input int s, input logic we, input logic [1:0] sz, input logic [9:0] a);
    issue(s, we, sz, 1'b0, a, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    #2;
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst_n = 2'b00; req_vld = 2'b00; req_we = 2'b00; req_signed = 2'b00; inj = 2'b00;
    for (int s = 0; s < 2; s++) begin
      req_size[s] = SZ_B; req_addr[s] = '0; req_wdata[s] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_rsp_vld[%0d]", s), rsp_vld[s], 1'b0);
      chk($sformatf("rst_align_err[%0d]", s), align_err[s], 1'b0);
      chk($sformatf("rst_unexp_err[%0d]", s), unexp_err[s], 1'b0);
      chk($sformatf("rst_mem_rd_en[%0d]", s), mem_rd_en[s], 1'b0);
      chk($sformatf("rst_req_rdy[%0d]", s), req_rdy[s], 1'b1);
    end
    @(negedge clk);
    rst_n = 2'b11;

    // Instance A: RD_LAT=1 alignment and extension.
    st(0, SZ_W, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    ld(0, SZ_W, 1'b0, 10'h010, 32'hDEAD_BEEF);
    st(0, SZ_B, 10'h013, 32'h1234_56A5, 4'b1000, 32'hA5A5_A5A5);
    ld(0, SZ_B, 1'b1, 10'h013, 32'hFFFF_FFA5);
    ld(0, SZ_B, 1'b0, 10'h013, 32'h0000_00A5);
    ld(0, SZ_B, 1'b1, 10'h012, 32'hFFFF_FFAD);
    st(0, SZ_W, 10'h010, 32'h8001_1234, 4'hF, 32'h8001_1234);
    ld(0, SZ_H, 1'b1, 10'h012, 32'hFFFF_8001);
    ld(0, SZ_H, 1'b1, 10'h010, 32'h0000_1234);
    bad(0, 1'b1, SZ_H, 10'h011);
    st(0, SZ_H, 10'h012, 32'h5555_BEEF, 4'b1100, 32'hBEEF_BEEF);
    ld(0, SZ_W, 1'b1, 10'h010, 32'hBEEF_1234);
    bad(0, 1'b0, SZ_X, 10'h010);
    ld(0, SZ_H, 1'b0, 10'h012, 32'h0000_BEEF);
    bad(0, 1'b0, SZ_W, 10'h012);
    ld(0, SZ_H, 1'b1, 10'h012, 32'hFFFF_BEEF);
    ld(0, SZ_B, 1'b0, 10'h011, 32'h0000_0012);
    st(0, SZ_B, 10'h3FF, 32'h0000_007E, 4'b1000, 32'h7E7E_7E7E);
    ld(0, SZ_B, 1'b1, 10'h3FF, 32'h0000_007E);
    drain();

    // Instance B: RD_LAT=3, MAX_OUTST=2 stall and ordering.
    st(1, SZ_W, 10'h000, 32'h1111_2222, 4'hF, 32'h1111_2222);
    st(1, SZ_W, 10'h004, 32'h3333_4444, 4'hF, 32'h3333_4444);
    st(1, SZ_W, 10'h008, 32'h5566_7788, 4'hF, 32'h5566_7788);
    ld(1, SZ_W, 1'b0, 10'h000, 32'h1111_2222);
    ld(1, SZ_W, 1'b0, 10'h004, 32'h3333_4444);
    @(negedge clk);
    req_vld[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = SZ_W; req_addr[1] = 10'h008;
    #1;
    chk("rdy_full_load", req_rdy[1], 1'b0);
    chk("rd_en_full_load", mem_rd_en[1], 1'b0);
    req_we[1] = 1'b1; req_addr[1] = 10'h040; req_wdata[1] = 32'hCAFE_F00D;
    #1;
    chk("rdy_store_stall", req_rdy[1], 1'b1);
    chk("wr_en_store_stall", mem_wr_en[1], 1'b1);
    @(posedge clk); #1;
    req_vld[1] = 1'b0;
    ld(1, SZ_H, 1'b0, 10'h006, 32'h0000_3333);
    ld(1, SZ_B, 1'b1, 10'h008, 32'hFFFF_FF88);
    ld(1, SZ_B, 1'b1, 10'h00B, 32'h0000_0055);
    ld(1, SZ_W, 1'b0, 10'h040, 32'hCAFE_F00D);
    drain();

    // Instance B: reset with two loads in flight, then quiet window.
    ld(1, SZ_W, 1'b0, 10'h000, 32'h1111_2222);
    ld(1, SZ_W, 1'b0, 10'h004, 32'h3333_4444);
    @(negedge clk);
    rst_n[1] = 1'b0;
    exp_q1.delete();
    exp_c1.delete();
    #1;
    chk("midrst_rsp_vld", rsp_vld[1], 1'b0);
    chk("midrst_unexp_err", unexp_err[1], 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("quiet_unexp_err", unexp_err[1], 1'b0);
    end
    @(negedge clk);
    inj[1] = 1'b1;
    @(negedge clk);
    inj[1] = 1'b0;
    #1;
    chk("unexp_err_set", unexp_err[1], 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("unexp_err_sticky", unexp_err[1], 1'b1);
    ld(1, SZ_H, 1'b1, 10'h004, 32'h0000_4444);
    drain();

    chk("unexp_err_a_clear", unexp_err[0], 1'b0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
